ternary_dot_seq: RTL
====================

# ternary_dot_seq

Sequencer that drives one integer-mode ternary MAC (`ternary_mac_simple`, REGISTERED behaviour, 1-cycle latency) to compute a dot product of a streamed activation/ternary-weight vector. It accepts a job length, consumes elements over a valid/ready stream, gates the MAC on zero weights, and returns the accumulated sum with non-zero/skip statistics. It sits between the TPU tile scheduler and a single MAC lane.

## Interface
Parameters:
- ACT_BITS, 16, activation width; signed.
- ACC_BITS, 32, accumulator width; signed; must be > ACT_BITS.
- MAX_LEN, 255, maximum vector length.
- LEN_W, $clog2(MAX_LEN+1), width of length and counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  element count; latched on accepted start; values > MAX_LEN saturate to MAX_LEN.
- abort  in  1  synchronous job cancel.
- busy  out  1  state != IDLE.
- in_valid / in_ready  in / out  1 / 1  element handshake.
- in_act  in  ACT_BITS  signed activation.
- in_weight  in  2  00=-1, 01=0, 10=+1, 11=invalid.
- mac_enable  out  1  MAC enable.
- mac_activation  out  ACT_BITS  to MAC.
- mac_weight  out  2  to MAC.
- mac_acc_in  out  ACC_BITS  to MAC.
- mac_acc_out  in  ACC_BITS  MAC registered result.
- res_valid / res_ready  out / in  1 / 1  result handshake.
- res_data  out  ACC_BITS  dot product.
- res_nz  out  LEN_W  count of ±1 weights.
- res_skip  out  LEN_W  count of 0/invalid weights.
- err  out  1  sticky: an invalid weight was seen in the current/last job.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE: on start, latch len, clear counters and err. len==0 → OUT directly with res_data=0, res_nz=0, res_skip=0. Otherwise → RUN.
- RUN: in_ready=1 (function of state only, not in_valid). Accept = in_valid && in_ready.
  - First accepted element: mac_enable=1 unconditionally, mac_acc_in=0 (clears stale MAC state even for zero weight).
  - Later elements: mac_enable=1 only for weight 00/10; mac_acc_in=mac_acc_out.
  - Weight 11: forwarded to MAC as 01, counted as skip, sets err.
  - mac_activation/mac_weight driven combinationally from in_*; mac_enable=0 when no accept.
  - Counters: elem++, nz++ or skip++ per accept. Accepting element number len → DRAIN.
- DRAIN: one cycle; in_ready=0; capture res_data<=mac_acc_out, res_nz, res_skip at cycle end → OUT.
- OUT: res_valid=1; outputs stable until res_ready; on res_valid&&res_ready → IDLE.
- start outside IDLE ignored. abort in RUN/DRAIN/OUT → IDLE next cycle, no result, err retained; abort in IDLE no effect. abort has priority over accept and result handshake in the same cycle.
- Arithmetic: two's complement, wraps modulo 2^ACC_BITS; no overflow flag.

## Timing
- Reset: state IDLE; busy, in_ready, mac_enable, res_valid, err = 0; res_data, res_nz, res_skip, counters = 0; mac_acc_in=0, mac_activation=0, mac_weight=01.
- start → RUN next cycle; in_ready rises cycle after start.
- With in_valid held high: N elements in N cycles, DRAIN 1 cycle, res_valid asserted N+2 cycles after start cycle.
- len==0: res_valid the cycle after start.
- Stream stalls (in_valid low) pause RUN without MAC enable; no timeout.
- Back-to-back: start may assert in the cycle after result handshake (IDLE).

## Test plan
- len=4, (act,w)=(5,+1),(-3,-1),(7,0),(2,+1) continuous → res_data=10, res_nz=3, res_skip=1, res_valid 6 cycles after start.
- Job A as above (10), then len=3 all weights 01 → res_data=0 (stale-clear check), res_nz=0, res_skip=3; MAC enabled only on first element.
- len=0 → res_valid cycle after start, res_data=0; err=0.
- len=2, (100,11),(-4,-1) → res_data=4, res_skip=1, err=1; err cleared on next start.
- res_ready low 5 cycles in OUT → res_valid/res_data stable; in_valid pulsed with in_ready=0, no accept; start ignored.
- abort after 2 of 5 elements → IDLE next cycle, no res_valid; new job len=1 (-8,+1) → -8. Async rst_n mid-RUN → all outputs at reset values immediately.

Source files
------------

// File: rtl/ternary_dot_seq.sv
// ternary_dot_seq: streams activation/ternary-weight pairs through one registered MAC lane
// and returns the dot product together with non-zero and skip counts.
module ternary_dot_seq #(
  parameter int ACT_BITS = 16,
  parameter int ACC_BITS = 32,
  parameter int MAX_LEN  = 255,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                abort,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ACT_BITS-1:0] in_act,
  input  logic [1:0]          in_weight,
  output logic                mac_enable,
  output logic [ACT_BITS-1:0] mac_activation,
  output logic [1:0]          mac_weight,
  output logic [ACC_BITS-1:0] mac_acc_in,
  input  logic [ACC_BITS-1:0] mac_acc_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ACC_BITS-1:0] res_data,
  output logic [LEN_W-1:0]    res_nz,
  output logic [LEN_W-1:0]    res_skip,
  output logic                err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  logic [1:0]          state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d, elem_q, elem_d, nz_q, nz_d, skip_q, skip_d;
  logic [LEN_W-1:0]    res_nz_q, res_nz_d, res_skip_q, res_skip_d;
  logic [ACC_BITS-1:0] res_q, res_d;
  logic                err_q, err_d;
  logic                acc, nzw, bad, first, last;
  logic [LEN_W-1:0]    len_sat;

  assign len_sat  = len > MAX_L ? MAX_L : len;
  assign in_ready = state_q == RUN;
  assign acc      = in_ready && in_valid && !abort;
  assign nzw      = in_weight == 2'b00 || in_weight == 2'b10;
  assign bad      = in_weight == 2'b11;
  assign first    = elem_q == '0;
  assign last     = elem_q == len_q - LEN_W'(1);

  // The first element always fires the MAC with a zero seed so stale lane state never leaks in.
  assign mac_enable     = acc && (first || nzw);
  assign mac_activation = acc ? in_act : '0;
  assign mac_weight     = acc && !bad ? in_weight : 2'b01;
  assign mac_acc_in     = acc && !first ? mac_acc_out : '0;

  assign busy      = state_q != IDLE;
  assign res_valid = state_q == OUT;
  assign res_data  = res_q;
  assign res_nz    = res_nz_q;
  assign res_skip  = res_skip_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    elem_d     = elem_q;
    nz_d       = nz_q;
    skip_d     = skip_q;
    err_d      = err_q;
    res_d      = res_q;
    res_nz_d   = res_nz_q;
    res_skip_d = res_skip_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          len_d      = len_sat;
          elem_d     = '0;
          nz_d       = '0;
          skip_d     = '0;
          err_d      = 1'b0;
          res_d      = '0;
          res_nz_d   = '0;
          res_skip_d = '0;
          state_d    = len_sat == '0 ? OUT : RUN;
        end
        RUN: if (acc) begin
          elem_d  = elem_q + LEN_W'(1);
          nz_d    = nz_q + LEN_W'(nzw);
          skip_d  = skip_q + LEN_W'(!nzw);
          err_d   = err_q | bad;
          state_d = last ? DRAIN : RUN;
        end
        DRAIN: begin
          res_d      = mac_acc_out;
          res_nz_d   = nz_q;
          res_skip_d = skip_q;
          state_d    = OUT;
        end
        default: state_d = res_ready ? IDLE : OUT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      elem_q     <= '0;
      nz_q       <= '0;
      skip_q     <= '0;
      err_q      <= 1'b0;
      res_q      <= '0;
      res_nz_q   <= '0;
      res_skip_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      elem_q     <= elem_d;
      nz_q       <= nz_d;
      skip_q     <= skip_d;
      err_q      <= err_d;
      res_q      <= res_d;
      res_nz_q   <= res_nz_d;
      res_skip_q <= res_skip_d;
    end
  end
endmodule
